// File: rtl/fpga_cfg_pkg.sv
// Shared types and chain-geometry constants for the configuration loader.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SET   = 3'd3,
    DONE  = 3'd4
  } cfg_state_t;

  localparam int CFG_WORD_W = 32;

  // Per-tile chain segments: two connection blocks, one switch box, one CLB.
  localparam int CFG_CB_BITS    = 12;
  localparam int CFG_SB_BITS    = 20;
  localparam int CFG_CLB_BITS   = 20;
  localparam int CFG_TILE_BITS  = 2 * CFG_CB_BITS + CFG_SB_BITS + CFG_CLB_BITS;
  localparam int CFG_NUM_TILES  = 16;
  localparam int CFG_CHAIN_LEN  = CFG_NUM_TILES * CFG_TILE_BITS;

endpackage

// File: rtl/fpga_config_loader_serializer.sv
// One-word shift register with a word-bit counter; LSB leaves first.
module cfg_word_serializer #(
  parameter int WORD_W = 32,
  parameter int WCNT_W = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              next_bit,
  output logic              empty
);

  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_next;
  logic [WCNT_W-1:0] wcnt;

  assign shreg_next = shreg >> 1;
  assign next_bit   = shreg_next[0];
  // High during the shift that drains the last bit of the word.
  assign empty      = (wcnt == WCNT_W'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      wcnt  <= '0;
    end else if (load) begin
      shreg <= data;
      wcnt  <= '0;
    end else if (shift) begin
      shreg <= shreg_next;
      wcnt  <= wcnt + WCNT_W'(1);
    end
  end

endmodule

// File: rtl/fpga_config_loader.sv
// Bitstream loader feeding the tile configuration chain, LSB-first, with a final set pulse.
// Optional readback of the old chain contents is built when FPGA_CONFIG_READBACK_EN is defined.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_W    = CFG_WORD_W,
  parameter int CHAIN_LEN = CFG_CHAIN_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              cfg_cen,
  output logic              cfg_shift,
  output logic              cfg_set,
  input  logic              cfg_return,
  output logic              busy,
  output logic              done,
  output cfg_state_t        dbg_state
`ifdef FPGA_CONFIG_READBACK_EN
  ,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
`endif
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(WORD_W + 1);

  // Handshake: a word transfers on a rising edge where word_valid && word_ready;
  // the host holds word_data stable while valid is high and ready is low.
  cfg_state_t       state;
  logic [CNT_W-1:0] bitcnt;
  logic             ser_load, ser_shift, ser_next_bit, ser_empty, chain_end;

  assign ser_load  = (state == LOAD) && word_valid && word_ready && !abort;
  assign ser_shift = (state == SHIFT) && !abort;
  assign chain_end = (bitcnt == CNT_W'(CHAIN_LEN - 1));
  assign dbg_state = state;

  cfg_word_serializer #(
    .WORD_W (WORD_W),
    .WCNT_W (WCNT_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .shift    (ser_shift),
    .data     (word_data),
    .next_bit (ser_next_bit),
    .empty    (ser_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bitcnt     <= '0;
      word_ready <= 1'b0;
      cfg_cen    <= 1'b0;
      cfg_shift  <= 1'b0;
      cfg_set    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cfg_set <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        word_ready <= 1'b0;
        cfg_cen    <= 1'b0;
        cfg_shift  <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state      <= LOAD;
              bitcnt     <= '0;
              word_ready <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
            end
          end
          LOAD: begin
            if (word_valid && word_ready) begin
              state      <= SHIFT;
              word_ready <= 1'b0;
              cfg_cen    <= 1'b1;
              cfg_shift  <= word_data[0];
            end
          end
          SHIFT: begin
            bitcnt <= bitcnt + CNT_W'(1);
            // Chain end wins over word end: leftover bits of the word are dropped.
            if (chain_end) begin
              state     <= SET;
              cfg_cen   <= 1'b0;
              cfg_shift <= 1'b0;
              cfg_set   <= 1'b1;
            end else if (ser_empty) begin
              state      <= LOAD;
              cfg_cen    <= 1'b0;
              cfg_shift  <= 1'b0;
              word_ready <= 1'b1;
            end else begin
              cfg_shift <= ser_next_bit;
            end
          end
          SET: begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FPGA_CONFIG_READBACK_EN
  logic [WORD_W-1:0] rb_sr, rb_full;
  logic [WORD_W:0]   rb_cat;
  logic [WCNT_W-1:0] rb_cnt;

  assign rb_cat  = {cfg_return, rb_sr};
  assign rb_full = rb_cat[WORD_W:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_sr    <= '0;
      rb_cnt   <= '0;
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else begin
      rb_valid <= 1'b0;
      if (ser_load) begin
        rb_cnt <= '0;
      end else if (ser_shift) begin
        rb_sr  <= rb_full;
        rb_cnt <= rb_cnt + WCNT_W'(1);
        // A short final word sits at the top of rb_full; shift it down to bit 0.
        if (ser_empty || chain_end) begin
          rb_valid <= 1'b1;
          rb_data  <= rb_full >> (WORD_W - 1 - int'(rb_cnt));
        end
      end
    end
  end
`else
  logic unused_return;
  assign unused_return = cfg_return;
`endif

endmodule

// File: tb/tb_fpga_config_loader.sv
// Bench for fpga_config_loader: three instances (chain lengths 64, 40, 32) with word width 32.
`timescale 1ns/1ps
module tb_fpga_config_loader;
  import fpga_cfg_pkg::*;

  localparam int W    = 32;
  localparam int NI   = 3;
  localparam int LEN0 = 64;
  localparam int LEN1 = 40;
  localparam int LEN2 = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         start[NI], abort[NI], word_valid[NI];
  logic [W-1:0] word_data[NI];
  logic         word_ready[NI], cfg_cen[NI], cfg_shift[NI], cfg_set[NI];
  logic         busy[NI], done[NI], cfg_return[NI];
  cfg_state_t   dbg_state[NI];
`ifdef FPGA_CONFIG_READBACK_EN
  logic         rb_valid[NI];
  logic [W-1:0] rb_data[NI];
  logic [W-1:0] rb_exp2;
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fpga_config_loader #(
      .WORD_W    (W),
      .CHAIN_LEN ((g == 0) ? LEN0 : (g == 1) ? LEN1 : LEN2)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .abort      (abort[g]),
      .word_valid (word_valid[g]),
      .word_data  (word_data[g]),
      .word_ready (word_ready[g]),
      .cfg_cen    (cfg_cen[g]),
      .cfg_shift  (cfg_shift[g]),
      .cfg_set    (cfg_set[g]),
      .cfg_return (cfg_return[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .dbg_state  (dbg_state[g])
`ifdef FPGA_CONFIG_READBACK_EN
      ,
      .rb_valid   (rb_valid[g]),
      .rb_data    (rb_data[g])
`endif
    );
  end

  // Fabric chain model behind instance 2: bit 0 is what the last tile shifts out.
  logic            chain_init;
  logic [LEN2-1:0] chain2;
  always @(posedge clk) begin
    if (chain_init) chain2 <= 32'hCAFEF00D;
    else if (cfg_cen[2]) chain2 <= {cfg_shift[2], chain2[LEN2-1:1]};
  end
  assign cfg_return[0] = 1'b0;
  assign cfg_return[1] = 1'b0;
  assign cfg_return[2] = chain2[0];

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int len_of(input int sel);
    return (sel == 0) ? LEN0 : (sel == 1) ? LEN1 : LEN2;
  endfunction

  logic [W-1:0] ld_words[2];
  int           ld_gaps[2];

  // Full load: start, feed words (withholding valid for ld_gaps[i] LOAD cycles before word i),
  // collect the chain stream and compare with the concatenated words, truncated to the chain length.
  task automatic run_load(input int sel, input int exp_total, input int poke_at, input string tag);
    int len, n_words, wi, gap_left, cyc, acc_edge, set_edge, last_cen_edge;
    int set_count, bad_bits, bad_gap, ready_late, shift_idle_hi, busy_bad, rb_count, rb_bad;
    logic exp_q[$];
    logic got_q[$];
    logic acc;
    len = len_of(sel);
    n_words = (len + W - 1) / W;
    for (int i = 0; i < len; i++) begin
      logic [W-1:0] w;
      w = ld_words[i / W];
      exp_q.push_back(w[i % W]);
    end
    start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    check({tag, " ready_after_start"}, word_ready[sel], 1);
    check({tag, " busy_after_start"}, busy[sel], 1);
    wi = 0; gap_left = ld_gaps[0]; cyc = 0; acc_edge = -1; set_edge = -1; last_cen_edge = -1;
    set_count = 0; bad_gap = 0; ready_late = 0; shift_idle_hi = 0; busy_bad = 0;
    rb_count = 0; rb_bad = 0;
    while (!done[sel] && cyc < 400) begin
      if (wi < n_words && word_ready[sel] && gap_left > 0) begin
        word_valid[sel] = 1'b0;
        word_data[sel]  = $urandom;
        gap_left--;
        if (cfg_cen[sel] !== 1'b0) bad_gap++;
      end else begin
        word_valid[sel] = (wi < n_words);
        word_data[sel]  = (wi < n_words) ? ld_words[wi] : W'($urandom);
      end
      if (wi >= n_words && word_ready[sel]) ready_late++;
      start[sel] = (poke_at >= 0 && got_q.size() == poke_at && cfg_cen[sel]);
      acc = word_valid[sel] && word_ready[sel];
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (acc_edge < 0) acc_edge = cyc;
        wi++;
        if (wi < n_words) gap_left = ld_gaps[wi];
      end
      if (cfg_cen[sel]) begin
        got_q.push_back(cfg_shift[sel]);
        last_cen_edge = cyc;
      end else if (cfg_shift[sel]) shift_idle_hi++;
      if (cfg_set[sel]) begin
        set_count++;
        set_edge = cyc;
      end
      if (!done[sel] && !busy[sel]) busy_bad++;
`ifdef FPGA_CONFIG_READBACK_EN
      if (rb_valid[sel]) begin
        rb_count++;
        if (sel == 2 && rb_data[sel] !== rb_exp2) rb_bad++;
        if (sel != 2 && rb_data[sel] !== '0) rb_bad++;
      end
`endif
    end
    word_valid[sel] = 1'b0;
    start[sel] = 1'b0;
    bad_bits = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad_bits++;
    check({tag, " bit_total"}, got_q.size(), len);
    check({tag, " stream_bad_bits"}, bad_bits, 0);
    check({tag, " set_count"}, set_count, 1);
    check({tag, " set_after_last_bit"}, set_edge, last_cen_edge + 1);
    check({tag, " done_after_set"}, cyc, set_edge + 1);
    check({tag, " cycles_accept_to_set"}, set_edge - acc_edge + 2, exp_total);
    check({tag, " done"}, done[sel], 1);
    check({tag, " busy_end"}, busy[sel], 0);
    check({tag, " ready_end"}, word_ready[sel], 0);
    check({tag, " state_end"}, dbg_state[sel], DONE);
    check({tag, " gap_cen"}, bad_gap, 0);
    check({tag, " shift_without_cen"}, shift_idle_hi, 0);
    check({tag, " ready_after_last_word"}, ready_late, 0);
    check({tag, " busy_during_load"}, busy_bad, 0);
`ifdef FPGA_CONFIG_READBACK_EN
    check({tag, " rb_count"}, rb_count, n_words);
    check({tag, " rb_data"}, rb_bad, 0);
    if (sel == 2) rb_exp2 = ld_words[0];
`endif
  endtask

  task automatic abort_test();
    int bits, cyc, set_seen, cen_seen, rdy_seen;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    word_valid[0] = 1'b1;
    word_data[0]  = $urandom;
    bits = 0; cyc = 0;
    while (bits < 10 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cfg_cen[0]) bits++;
    end
    check("abort reached_bit10", bits, 10);
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    check("abort state_idle", dbg_state[0], IDLE);
    check("abort busy", busy[0], 0);
    check("abort cen", cfg_cen[0], 0);
    check("abort set", cfg_set[0], 0);
    check("abort ready", word_ready[0], 0);
    set_seen = 0; cen_seen = 0; rdy_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      set_seen += int'(cfg_set[0]);
      cen_seen += int'(cfg_cen[0]);
      rdy_seen += int'(word_ready[0]);
    end
    word_valid[0] = 1'b0;
    check("abort no_set_after", set_seen, 0);
    check("abort no_cen_after", cen_seen, 0);
    check("abort no_ready_after", rdy_seen, 0);
  endtask

  task automatic rst_test();
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    word_valid[1] = 1'b1;
    word_data[1]  = 32'hFFFF_FFFF;
    repeat (6) @(posedge clk);
    #1;
    check("rst pre_shifting", cfg_cen[1], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    word_valid[1] = 1'b0;
    check("rst ready", word_ready[1], 0);
    check("rst cen", cfg_cen[1], 0);
    check("rst shift", cfg_shift[1], 0);
    check("rst set", cfg_set[1], 0);
    check("rst busy", busy[1], 0);
    check("rst done", done[1], 0);
    check("rst state", dbg_state[1], IDLE);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int          sel;
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap;
    int          poke;
    int          exp_total;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    int len, nw, poke, exp_total;
    vecs[0] = '{0, 32'hDEADBEEF, 32'h12345678, 0, -1, 67};
    vecs[1] = '{1, 32'hFFFFFFFF, 32'h000000AB, 0, -1, 43};
    vecs[2] = '{0, 32'hA5A5A5A5, 32'h0F0F0F0F, 5, -1, 72};
    vecs[3] = '{1, 32'h00000000, 32'hFFFFFF55, 5, -1, 48};
    vecs[4] = '{0, 32'h13579BDF, 32'h2468ACE0, 0, 17, 67};
    vecs[5] = '{2, 32'h600DF00D, 32'h00000000, 0, -1, 34};
    vecs[6] = '{2, 32'h0BADC0DE, 32'h00000000, 0, 9, 34};

    rst = 1'b1;
    chain_init = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; word_valid[i] = 1'b0; word_data[i] = '0;
    end
`ifdef FPGA_CONFIG_READBACK_EN
    rb_exp2 = 32'hCAFEF00D;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset%0d ready", i), word_ready[i], 0);
      check($sformatf("reset%0d cen", i), cfg_cen[i], 0);
      check($sformatf("reset%0d shift", i), cfg_shift[i], 0);
      check($sformatf("reset%0d set", i), cfg_set[i], 0);
      check($sformatf("reset%0d busy", i), busy[i], 0);
      check($sformatf("reset%0d done", i), done[i], 0);
      check($sformatf("reset%0d state", i), dbg_state[i], IDLE);
`ifdef FPGA_CONFIG_READBACK_EN
      check($sformatf("reset%0d rb_valid", i), rb_valid[i], 0);
      check($sformatf("reset%0d rb_data", i), rb_data[i], 0);
`endif
    end
    rst = 1'b0;
    chain_init = 1'b0;

    for (int v = 0; v < NV; v++) begin
      ld_words[0] = vecs[v].w0;
      ld_words[1] = vecs[v].w1;
      ld_gaps[0]  = 0;
      ld_gaps[1]  = vecs[v].gap;
      run_load(vecs[v].sel, vecs[v].exp_total, vecs[v].poke, $sformatf("vec%0d", v));
    end

    abort[1] = 1'b1;
    @(posedge clk); #1;
    abort[1] = 1'b0;
    check("abort_in_done done", done[1], 0);
    check("abort_in_done state", dbg_state[1], IDLE);

    abort_test();
    ld_words[0] = 32'h8000_0001; ld_words[1] = 32'h7FFF_FFFE; ld_gaps[0] = 0; ld_gaps[1] = 0;
    run_load(0, 67, -1, "after_abort");

    for (int r = 0; r < 16; r++) begin
      int sel;
      sel = $urandom_range(0, 1);
      len = len_of(sel);
      nw  = (len + W - 1) / W;
      ld_words[0] = $urandom;
      ld_words[1] = $urandom;
      ld_gaps[0]  = $urandom_range(0, 3);
      ld_gaps[1]  = $urandom_range(0, 6);
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len - 1)) : -1;
      exp_total = nw * (W + 1) - (nw * W - len) + 1 + ld_gaps[1];
      run_load(sel, exp_total, poke, $sformatf("rand%0d", r));
    end

    rst_test();
    ld_words[0] = 32'h0000_00FF; ld_words[1] = 32'h0000_0055; ld_gaps[0] = 1; ld_gaps[1] = 2;
    run_load(1, 45, -1, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
